// File: rtl/seq_checker.sv
// seq_checker: aligns to the cyclic 1,9,3,5 symbol pattern and reports mismatches and good periods.
// Locking needs LOCK_CNT clean periods; lock is lost after LOSS_CNT consecutive misses.
module seq_checker #(
   parameter int LOCK_CNT = 2,
   parameter int LOSS_CNT = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_vld,
   input  logic [3:0]       din,
   output logic             locked,
   output logic             err,
   output logic             period_done,
   output logic [3:0]       exp,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] period_cnt
);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(LOSS_CNT + 1);
   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
   state_t state, state_n;
   logic [1:0] idx, idx_n;
   logic [GW-1:0] good, good_n, good_inc;
   logic [MW-1:0] miss, miss_n, miss_inc;
   logic err_n, pd_n, match;
   function automatic logic [3:0] pat(input logic [1:0] i);
      return i == 2'd0 ? 4'd1 : i == 2'd1 ? 4'd9 : i == 2'd2 ? 4'd3 : 4'd5;
   endfunction
   assign match = din == pat(idx);
   assign good_inc = good + GW'(1);
   assign miss_inc = miss + MW'(1);
   assign locked = state == LOCKED;
   assign exp = state == HUNT ? 4'd1 : pat(idx);
   always_comb begin
      state_n = state;
      idx_n = idx;
      good_n = good;
      miss_n = miss;
      err_n = 1'b0;
      pd_n = 1'b0;
      if (din_vld) begin
         unique case (state)
            HUNT: if (din == 4'd1) begin
               state_n = SYNC;
               idx_n = 2'd1;
               good_n = '0;
            end
            SYNC: if (match) begin
               idx_n = idx + 2'd1;
               if (idx == 2'd3) begin
                  good_n = good_inc;
                  if (good_inc == GW'(LOCK_CNT)) begin
                     state_n = LOCKED;
                     idx_n = 2'd0;
                     miss_n = '0;
                  end
               end
            end else if (din == 4'd1) begin
               idx_n = 2'd1;
               good_n = '0;
            end else begin
               state_n = HUNT;
               idx_n = 2'd0;
            end
            LOCKED: begin
               // Flywheel: the index advances on every symbol, good or bad.
               idx_n = idx + 2'd1;
               if (match) begin
                  miss_n = '0;
                  pd_n = idx == 2'd3;
               end else begin
                  err_n = 1'b1;
                  miss_n = miss_inc;
                  if (miss_inc == MW'(LOSS_CNT)) begin
                     state_n = HUNT;
                     idx_n = 2'd0;
                  end
               end
            end
            default: begin
               state_n = HUNT;
               idx_n = 2'd0;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         idx <= 2'd0;
         good <= '0;
         miss <= '0;
         err <= 1'b0;
         period_done <= 1'b0;
         err_cnt <= '0;
         period_cnt <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         good <= good_n;
         miss <= miss_n;
         err <= err_n;
         period_done <= pd_n;
         err_cnt <= err_cnt + CNT_W'(err_n && err_cnt != '1);
         period_cnt <= period_cnt + CNT_W'(pd_n && period_cnt != '1);
      end
   end
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed scoreboard bench; dut1 uses defaults, dut2 uses LOCK_CNT=1, LOSS_CNT=1, CNT_W=2.
module tb_seq_checker;
   typedef struct packed {
      logic       l, e, p;
      logic [3:0] x;
      logic [7:0] ec, pc;
   } obs_t;
   logic clk = 1'b0, rst = 1'b1, vld1 = 1'b0, vld2 = 1'b0;
   logic [3:0] din1 = '0, din2 = '0;
   logic a_locked, a_err, a_pd, b_locked, b_err, b_pd;
   logic [3:0] a_exp, b_exp;
   logic [7:0] a_ec, a_pc;
   logic [1:0] b_ec, b_pc;
   obs_t sb[$];
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   seq_checker dut1 (
      .clk(clk), .rst(rst), .din_vld(vld1), .din(din1), .locked(a_locked), .err(a_err),
      .period_done(a_pd), .exp(a_exp), .err_cnt(a_ec), .period_cnt(a_pc)
   );
   seq_checker #(.LOCK_CNT(1), .LOSS_CNT(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .din_vld(vld2), .din(din2), .locked(b_locked), .err(b_err),
      .period_done(b_pd), .exp(b_exp), .err_cnt(b_ec), .period_cnt(b_pc)
   );
   task automatic cmp(input string tag, input int obs, input int req);
      tests++;
      assert (obs === req) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, req, $time);
      end
   endtask
   task automatic chk(input bit u, input logic r, v, input logic [3:0] d,
                      input logic l, e, p, input logic [3:0] x, input int ec, pc);
      obs_t o, w;
      rst = r;
      vld1 = u ? 1'b0 : v;
      vld2 = u ? v : 1'b0;
      if (u) din2 = d; else din1 = d;
      sb.push_back({l, e, p, x, 8'(ec), 8'(pc)});
      @(posedge clk);
      #1;
      w = sb.pop_front();
      o = u ? {b_locked, b_err, b_pd, b_exp, {6'b0, b_ec}, {6'b0, b_pc}}
            : {a_locked, a_err, a_pd, a_exp, a_ec, a_pc};
      cmp(u ? "dut2.locked" : "dut1.locked", int'(o.l), int'(w.l));
      cmp(u ? "dut2.err" : "dut1.err", int'(o.e), int'(w.e));
      cmp(u ? "dut2.period_done" : "dut1.period_done", int'(o.p), int'(w.p));
      cmp(u ? "dut2.exp" : "dut1.exp", int'(o.x), int'(w.x));
      cmp(u ? "dut2.err_cnt" : "dut1.err_cnt", int'(o.ec), int'(w.ec));
      cmp(u ? "dut2.period_cnt" : "dut1.period_cnt", int'(o.pc), int'(w.pc));
   endtask
   initial begin
      int e2, p2;
      #1;
      // reset state
      chk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      // two clean periods lock on the 8th symbol
      for (int i = 0; i < 2; i++) begin
         chk(0, 0, 1, 1, 0, 0, 0, 9, 0, 0);
         chk(0, 0, 1, 9, 0, 0, 0, 3, 0, 0);
         chk(0, 0, 1, 3, 0, 0, 0, 5, 0, 0);
         chk(0, 0, 1, 5, i == 1, 0, 0, 1, 0, 0);
      end
      for (int k = 1; k <= 4; k++) begin
         chk(0, 0, 1, 1, 1, 0, 0, 9, 0, k - 1);
         chk(0, 0, 1, 9, 1, 0, 0, 3, 0, k - 1);
         chk(0, 0, 1, 3, 1, 0, 0, 5, 0, k - 1);
         chk(0, 0, 1, 5, 1, 0, 1, 1, 0, k);
      end
      // single bad symbol: flywheel keeps the index, period still completes
      chk(0, 0, 1, 1, 1, 0, 0, 9, 0, 4);
      chk(0, 0, 1, 9, 1, 0, 0, 3, 0, 4);
      chk(0, 0, 1, 7, 1, 1, 0, 5, 1, 4);
      chk(0, 0, 1, 5, 1, 0, 1, 1, 1, 5);
      // two consecutive misses lose lock
      chk(0, 0, 1, 0, 1, 1, 0, 9, 2, 5);
      chk(0, 0, 1, 0, 0, 1, 0, 1, 3, 5);
      chk(0, 0, 1, 0, 0, 0, 0, 1, 3, 5);
      // re-arm in SYNC on a stray 1, then lock
      chk(0, 0, 1, 1, 0, 0, 0, 9, 3, 5);
      chk(0, 0, 1, 9, 0, 0, 0, 3, 3, 5);
      chk(0, 0, 1, 1, 0, 0, 0, 9, 3, 5);
      chk(0, 0, 1, 9, 0, 0, 0, 3, 3, 5);
      chk(0, 0, 1, 3, 0, 0, 0, 5, 3, 5);
      chk(0, 0, 1, 5, 0, 0, 0, 1, 3, 5);
      chk(0, 0, 1, 1, 0, 0, 0, 9, 3, 5);
      chk(0, 0, 1, 9, 0, 0, 0, 3, 3, 5);
      chk(0, 0, 1, 3, 0, 0, 0, 5, 3, 5);
      chk(0, 0, 1, 5, 1, 0, 0, 1, 3, 5);
      // gaps hold everything and suppress pulses
      chk(0, 0, 1, 1, 1, 0, 0, 9, 3, 5);
      chk(0, 0, 0, 5, 1, 0, 0, 9, 3, 5);
      chk(0, 0, 1, 9, 1, 0, 0, 3, 3, 5);
      chk(0, 0, 0, 0, 1, 0, 0, 3, 3, 5);
      chk(0, 0, 1, 3, 1, 0, 0, 5, 3, 5);
      chk(0, 0, 0, 1, 1, 0, 0, 5, 3, 5);
      chk(0, 0, 1, 5, 1, 0, 1, 1, 3, 6);
      chk(0, 0, 0, 5, 1, 0, 0, 1, 3, 6);
      chk(0, 0, 1, 1, 1, 0, 0, 9, 3, 6);
      chk(0, 0, 1, 2, 1, 1, 0, 3, 4, 6);
      chk(0, 0, 0, 2, 1, 0, 0, 3, 4, 6);
      chk(0, 0, 1, 3, 1, 0, 0, 5, 4, 6);
      chk(0, 0, 1, 5, 1, 0, 1, 1, 4, 7);
      // mid-period reset dominates valid input
      chk(0, 0, 1, 1, 1, 0, 0, 9, 4, 7);
      chk(0, 0, 1, 9, 1, 0, 0, 3, 4, 7);
      chk(0, 1, 1, 3, 0, 0, 0, 1, 0, 0);
      chk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
      chk(0, 0, 1, 1, 0, 0, 0, 9, 0, 0);
      // dut2: one-period lock, one-miss loss, 2-bit saturating counters
      chk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      e2 = 0;
      p2 = 0;
      for (int k = 0; k < 4; k++) begin
         chk(1, 0, 1, 1, 0, 0, 0, 9, e2, p2);
         chk(1, 0, 1, 9, 0, 0, 0, 3, e2, p2);
         chk(1, 0, 1, 3, 0, 0, 0, 5, e2, p2);
         chk(1, 0, 1, 5, 1, 0, 0, 1, e2, p2);
         if (k == 0)
            for (int j = 0; j < 4; j++) begin
               chk(1, 0, 1, 1, 1, 0, 0, 9, e2, p2);
               chk(1, 0, 1, 9, 1, 0, 0, 3, e2, p2);
               chk(1, 0, 1, 3, 1, 0, 0, 5, e2, p2);
               p2 = p2 < 3 ? p2 + 1 : 3;
               chk(1, 0, 1, 5, 1, 0, 1, 1, e2, p2);
            end
         e2 = e2 < 3 ? e2 + 1 : 3;
         chk(1, 0, 1, 0, 0, 1, 0, 1, e2, p2);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
